lfsr_random_reader: RTL and testbench

- Consumer end of the 64-bit pseudo-random word stream produced by the LFSR generator.
- Captures each word on the generator's avail strobe into a small word FIFO and throttles the generator through its clock-enable.
- Serves narrower random slices to sequencer logic on a req/ack handshake.
- Each served slice also carries a Bernoulli decision bit (slice < threshold) for randomized pulse/branch selection.

---
 rtl/lfsr_random_reader.sv | 123 ++++++++++++
 tb/tb_lfsr_random_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_random_reader.sv
// lfsr_random_reader
//   Consumer end of the LFSR generator's 64-bit word stream. Words arriving on
//   word_avail are buffered in a small FIFO; the generator is throttled through
//   gen_ce. Sequencer logic pulls SLICE_W-bit slices (LSB slice first) through a
//   req/ack handshake, and each slice carries a Bernoulli bit (slice < threshold).
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   word_in     random word from the generator
//   word_avail  one-cycle strobe, word_in valid
//   gen_ce      generator clock-enable, high while the FIFO has room
//   req         one-cycle request for one slice
//   threshold   compare value for bit_out, sampled with req
//   data_out    served slice, held until the next ack
//   bit_out     data_out < threshold, held with data_out
//   ack         one-cycle strobe, data_out/bit_out updated
//   underflow   one-cycle strobe, req arrived with nothing buffered
//   drop_count  words discarded on a full FIFO, saturating
//   level       words currently stored
module lfsr_random_reader #(
    parameter int WORD_W  = 64,
    parameter int SLICE_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WORD_W-1:0]          word_in,
    input  logic                       word_avail,
    output logic                       gen_ce,
    input  logic                       req,
    input  logic [SLICE_W-1:0]         threshold,
    output logic [SLICE_W-1:0]         data_out,
    output logic                       bit_out,
    output logic                       ack,
    output logic                       underflow,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int NSLICE = WORD_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NSLICE - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] SLACK_LVL = LVL_W'(DEPTH - 1);

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [IDX_W-1:0]   slice_idx;

    logic               serve;
    logic               pop;
    logic               push;
    logic               drop;
    logic [LVL_W-1:0]   next_level;
    logic [SLICE_W-1:0] cur_slice;

    // A request is served only from words already stored; a word written in the
    // same cycle is not visible to it.
    assign serve = req && (level != '0);
    assign pop   = serve && (slice_idx == LAST_IDX);
    // A full FIFO still accepts a word when the head is popped in the same cycle.
    assign push  = word_avail && ((level < FULL_LVL) || pop);
    assign drop  = word_avail && !push;

    assign next_level = level + LVL_W'(push) - LVL_W'(pop);
    assign cur_slice  = SLICE_W'(mem[rd_ptr] >> (SLICE_W * int'(slice_idx)));

    // NOTE: the word storage has no reset; pointers and level define validity,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word_in;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            slice_idx  <= '0;
            level      <= '0;
            gen_ce     <= 1'b0;
            data_out   <= '0;
            bit_out    <= 1'b0;
            ack        <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
        end else begin
            level     <= next_level;
            // One word of slack covers a strobe already in flight when gen_ce drops.
            gen_ce    <= (next_level < SLACK_LVL);
            ack       <= serve;
            underflow <= req && (level == '0);

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (serve) begin
                data_out <= cur_slice;
                bit_out  <= (cur_slice < threshold);
                if (pop) begin
                    slice_idx <= '0;
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                end else begin
                    slice_idx <= slice_idx + IDX_W'(1);
                end
            end

            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_random_reader.sv
// Directed bench for lfsr_random_reader: slicing order, underflow, FIFO full
// behaviour with gen_ce throttling, Bernoulli bit, mid-run reset and
// drop_count saturation.
module tb_lfsr_random_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] word_in;
    logic        word_avail;
    logic        gen_ce;
    logic        req;
    logic [15:0] threshold;
    logic [15:0] data_out;
    logic        bit_out;
    logic        ack;
    logic        underflow;
    logic [15:0] drop_count;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    lfsr_random_reader #(.WORD_W(64), .SLICE_W(16), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .word_in    (word_in),
        .word_avail (word_avail),
        .gen_ce     (gen_ce),
        .req        (req),
        .threshold  (threshold),
        .data_out   (data_out),
        .bit_out    (bit_out),
        .ack        (ack),
        .underflow  (underflow),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic push_word(input logic [63:0] w);
        word_avail = 1'b1;
        word_in    = w;
        tick();
        word_avail = 1'b0;
    endtask

    task automatic single_req(input logic [15:0] thr);
        req       = 1'b1;
        threshold = thr;
        tick();
        req       = 1'b0;
    endtask

    logic [15:0] exp_sl [4];
    logic [0:0]  exp_bit [4];

    initial begin
        reset_n    = 1'b0;
        word_in    = '0;
        word_avail = 1'b0;
        req        = 1'b0;
        threshold  = '0;

        // Reset state
        do_reset();
        check("rst_level", 64'(level), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        tick();
        check("gen_ce_after_rst", 64'(gen_ce), 64'd1);

        // Slicing order, LSB slice first, level drops after the last slice
        push_word(64'h0123_4567_89AB_CDEF);
        check("lvl_after_push", 64'(level), 64'd1);
        exp_sl[0] = 16'hCDEF; exp_sl[1] = 16'h89AB;
        exp_sl[2] = 16'h4567; exp_sl[3] = 16'h0123;
        for (int i = 0; i < 4; i++) begin
            single_req(16'h0000);
            check($sformatf("slice%0d_ack", i), 64'(ack), 64'd1);
            check($sformatf("slice%0d_data", i), 64'(data_out), 64'(exp_sl[i]));
            check($sformatf("slice%0d_bit_thr0", i), 64'(bit_out), 64'd0);
            check($sformatf("slice%0d_level", i), 64'(level), (i == 3) ? 64'd0 : 64'd1);
            tick();
            check($sformatf("slice%0d_ack_drop", i), 64'(ack), 64'd0);
        end

        // Underflow on an empty FIFO after reset
        do_reset();
        single_req(16'h0000);
        check("uf_pulse", 64'(underflow), 64'd1);
        check("uf_no_ack", 64'(ack), 64'd0);
        check("uf_data_hold", 64'(data_out), 64'd0);
        tick();
        check("uf_one_cycle", 64'(underflow), 64'd0);

        // Fill, gen_ce throttling, drop on full, push accepted alongside a pop
        do_reset();
        tick();
        push_word(64'h1004_1003_1002_1001);
        check("fill1_gen_ce", 64'(gen_ce), 64'd1);
        push_word(64'h2004_2003_2002_2001);
        check("fill2_gen_ce", 64'(gen_ce), 64'd1);
        push_word(64'h3004_3003_3002_3001);
        check("fill3_gen_ce", 64'(gen_ce), 64'd0);
        push_word(64'h4004_4003_4002_4001);
        check("fill4_level", 64'(level), 64'd4);
        push_word(64'h5004_5003_5002_5001);
        check("full_drop", 64'(drop_count), 64'd1);
        check("full_level", 64'(level), 64'd4);
        for (int i = 0; i < 3; i++) begin
            single_req(16'h0000);
            check($sformatf("full_slice%0d", i), 64'(data_out), 64'(16'h1001 + 16'(i)));
        end
        req        = 1'b1;
        word_avail = 1'b1;
        word_in    = 64'h6004_6003_6002_6001;
        tick();
        req        = 1'b0;
        word_avail = 1'b0;
        check("pop_push_data", 64'(data_out), 64'h1004);
        check("pop_push_level", 64'(level), 64'd4);
        check("pop_push_drop", 64'(drop_count), 64'd1);
        single_req(16'h0000);
        check("next_head_word", 64'(data_out), 64'h2001);

        // Bernoulli bit, back-to-back requests
        do_reset();
        push_word(64'h0000_0000_FFFF_8000);
        exp_sl[0] = 16'h8000; exp_sl[1] = 16'hFFFF;
        exp_sl[2] = 16'h0000; exp_sl[3] = 16'h0000;
        exp_bit[0] = 1'b0; exp_bit[1] = 1'b0; exp_bit[2] = 1'b1; exp_bit[3] = 1'b1;
        req       = 1'b1;
        threshold = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b2b%0d_ack", i), 64'(ack), 64'd1);
            check($sformatf("b2b%0d_data", i), 64'(data_out), 64'(exp_sl[i]));
            check($sformatf("b2b%0d_bit", i), 64'(bit_out), 64'(exp_bit[i]));
        end
        req = 1'b0;
        tick();
        check("b2b_level", 64'(level), 64'd0);
        check("b2b_ack_end", 64'(ack), 64'd0);

        // Reset mid-operation with level=3 and slice index=2
        do_reset();
        push_word(64'h1111_2222_3333_4444);
        push_word(64'h5555_6666_7777_8888);
        push_word(64'h9999_AAAA_BBBB_CCCC);
        single_req(16'h0000);
        single_req(16'h0000);
        check("pre_rst_data", 64'(data_out), 64'h3333);
        check("pre_rst_level", 64'(level), 64'd3);
        reset_n = 1'b0;
        req     = 1'b1;
        tick();
        req     = 1'b0;
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_data", 64'(data_out), 64'd0);
        check("mid_rst_gen_ce", 64'(gen_ce), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        reset_n = 1'b1;
        tick();
        single_req(16'h0000);
        check("post_rst_uf", 64'(underflow), 64'd1);
        check("post_rst_no_ack", 64'(ack), 64'd0);

        // drop_count saturation
        do_reset();
        word_avail = 1'b1;
        word_in    = 64'hDEAD_BEEF_0000_0001;
        repeat (70000) @(posedge clk);
        #1;
        word_avail = 1'b0;
        check("sat_drop", 64'(drop_count), 64'hFFFF);
        check("sat_level", 64'(level), 64'd4);
        tick();
        check("sat_hold", 64'(drop_count), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
